run_ctrl: RTL and testbench

//  Processor-side run controller answering the Start/Ack handshake that benches drive on TopLevel.

---
 rtl/run_ctrl.sv | 138 +++++++++++++
 tb/tb_run_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: processor-side run controller for the Start/Ack handshake.
//
// Sits beside the PC and decoder. While start_i is high it holds the PC at
// zero (armed/load). When start_i falls it launches execution. The run stops
// on the decoder halt or on a watchdog timeout. ack_o then stays high until
// the next start. Cycles and retired instructions are counted for each run.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous, active-high reset
//   start_i        high = arm/load, falling = launch
//   halt_i         decoder: halt instruction executing this cycle
//   inst_retire_i  one instruction completed this cycle
//   pc_init_o      force PC to 0
//   run_en_o       enables PC advance, reg file and data memory writes
//   ack_o          program done (level, held until next start)
//   timed_out_o    last run ended by the watchdog, not by halt
//   cycle_cnt_o    RUN cycles of the current/last run (saturating)
//   inst_cnt_o     instructions retired in the current/last run (saturating)
//
// Parameters:
//   CNT_W    counter width
//   TIMEOUT  maximum RUN cycles before a forced stop; 0 disables the watchdog
//
// State table:
//   IDLE  | after reset, PC held at 0, waiting for start
//   ARMED | start high, PC held at 0, counters cleared
//   RUN   | program executing, counters advancing
//   DONE  | halted or timed out, ack high, counters frozen
module run_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             inst_retire_i,
  output logic             pc_init_o,
  output logic             run_en_o,
  output logic             ack_o,
  output logic             timed_out_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] inst_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TO_VAL = TIMEOUT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic             to_q, to_d;

  logic [CNT_W-1:0] cyc_inc;
  logic [CNT_W-1:0] inst_inc;
  logic             wd_hit;

  // The counters saturate rather than wrap, so a very long run still reads
  // as "at least this many".
  assign cyc_inc  = (&cyc_q)  ? cyc_q  : cyc_q + ONE;
  assign inst_inc = (&inst_q) ? inst_q : inst_q + ONE;

  // The watchdog compares against the post-increment count. The run
  // therefore stops with cycle_cnt_o equal to TIMEOUT exactly.
  assign wd_hit = (TIMEOUT != 0) && (cyc_inc == TO_VAL);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      inst_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    inst_d  = inst_q;
    to_d    = to_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!start_i) state_d = S_RUN;
      end
      S_RUN: begin
        // The cycle that samples halt (or the timeout) is itself counted.
        cyc_d = cyc_inc;
        if (inst_retire_i) inst_d = inst_inc;
        // Start (abort) wins over halt. Halt wins over a coincident timeout,
        // because the program really did finish.
        if (start_i) begin
          state_d = S_ARMED;
        end else if (halt_i) begin
          state_d = S_DONE;
        end else if (wd_hit) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end
      end
      S_DONE: begin
        if (start_i) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase

    // Every entry into ARMED starts a fresh run record.
    if (state_d == S_ARMED) begin
      cyc_d  = '0;
      inst_d = '0;
      to_d   = 1'b0;
    end
  end

  assign pc_init_o   = (state_q == S_IDLE) || (state_q == S_ARMED);
  assign run_en_o    = (state_q == S_RUN);
  assign ack_o       = (state_q == S_DONE);
  assign timed_out_o = to_q;
  assign cycle_cnt_o = cyc_q;
  assign inst_cnt_o  = inst_q;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, halt, retire;
  logic             pc_init, run_en, ack, timed_out;
  logic [CNT_W-1:0] cyc, inst;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  run_ctrl #(.CNT_W(CNT_W), .TIMEOUT(50)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .halt_i        (halt),
    .inst_retire_i (retire),
    .pc_init_o     (pc_init),
    .run_en_o      (run_en),
    .ack_o         (ack),
    .timed_out_o   (timed_out),
    .cycle_cnt_o   (cyc),
    .inst_cnt_o    (inst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot: pc_init, run_en, ack, timed_out, cycles, insts.
  task automatic chk_all(input string tag, input logic p, input logic r, input logic a,
                         input logic t, input int c, input int i);
    chk({tag, ".pc_init"}, 32'(pc_init), 32'(p));
    chk({tag, ".run_en"}, 32'(run_en), 32'(r));
    chk({tag, ".ack"}, 32'(ack), 32'(a));
    chk({tag, ".timed_out"}, 32'(timed_out), 32'(t));
    chk({tag, ".cycles"}, 32'(cyc), 32'(c));
    chk({tag, ".insts"}, 32'(inst), 32'(i));
  endtask

  // Arm for one cycle, then launch. On return the current cycle is RUN cycle 1.
  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  // Run n RUN cycles with halt on the last one. Retire on every cycle, or
  // only on odd cycles when odd_only is set.
  task automatic run_halt(input int n, input bit odd_only);
    for (int k = 1; k <= n; k++) begin
      halt   = (k == n);
      retire = odd_only ? k[0] : 1'b1;
      step();
    end
    halt   = 1'b0;
    retire = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; retire = 1'b0;
    #1;
    chk_all("reset", 1, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;

    // Halt/retire in IDLE are ignored.
    halt = 1'b1; retire = 1'b1;
    step(); step();
    halt = 1'b0; retire = 1'b0;
    chk_all("idle_ign", 1, 0, 0, 0, 0, 0);

    // Start held 5 cycles with halt/retire pulses: stays ARMED.
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      halt = k[0]; retire = 1'b1;
      step();
    end
    halt = 1'b0; retire = 1'b0;
    chk_all("armed_hold", 1, 0, 0, 0, 0, 0);

    // Normal run: halt on RUN cycle 20, retire every cycle.
    start = 1'b0;
    step();
    chk_all("launch", 0, 1, 0, 0, 0, 0);
    run_halt(20, 1'b0);
    chk_all("normal_done", 0, 0, 1, 0, 20, 20);

    // Halt/retire in DONE are ignored and the counters stay frozen.
    halt = 1'b1; retire = 1'b1;
    step(); step();
    halt = 1'b0; retire = 1'b0;
    chk_all("done_ign", 0, 0, 1, 0, 20, 20);

    // Back-to-back programs: 5, 12 (odd-cycle retire), 3.
    start = 1'b1;
    step();
    chk_all("b2b_arm1", 1, 0, 0, 0, 0, 0);
    start = 1'b0;
    step();
    run_halt(5, 1'b0);
    chk_all("b2b_run1", 0, 0, 1, 0, 5, 5);
    launch();
    run_halt(12, 1'b1);
    chk_all("b2b_run2", 0, 0, 1, 0, 12, 6);
    launch();
    run_halt(3, 1'b0);
    chk_all("b2b_run3", 0, 0, 1, 0, 3, 3);

    // Watchdog at 50 cycles, no halt, no retire.
    launch();
    for (int k = 0; k < 49; k++) step();
    chk_all("wd_49", 0, 1, 0, 0, 49, 0);
    step();
    chk_all("wd_hit", 0, 0, 1, 1, 50, 0);
    step(); step();
    chk_all("wd_frozen", 0, 0, 1, 1, 50, 0);

    // Abort at RUN cycle 7 (also clears the previous timed_out), then relaunch.
    launch();
    retire = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk_all("abort_pre", 0, 1, 0, 0, 6, 6);
    start = 1'b1;
    step();
    retire = 1'b0;
    chk_all("abort", 1, 0, 0, 0, 0, 0);
    start = 1'b0;
    step();
    run_halt(4, 1'b0);
    chk_all("abort_relaunch", 0, 0, 1, 0, 4, 4);

    // Start and halt together in RUN: start wins.
    launch();
    start = 1'b1; halt = 1'b1;
    step();
    start = 1'b0; halt = 1'b0;
    chk_all("start_over_halt", 1, 0, 0, 0, 0, 0);

    // Async reset mid-RUN with cycle count 9.
    step();
    retire = 1'b1;
    for (int k = 0; k < 9; k++) step();
    retire = 1'b0;
    chk_all("pre_rst", 0, 1, 0, 0, 9, 9);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    chk_all("post_rst", 1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
